// File: rtl/chinx_timer.sv
// Multi-channel system timer: shared prescaler feeding CHANNELS down-counters with a register file.
// Define CHINX_TIMER_TOGGLE_EN for legacy square-wave irq outputs (toggle on every expiry).
module chinx_timer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned PRESCALE = 10000,
  localparam int unsigned ADDR_W  = $clog2(CHANNELS) + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  output logic [CHANNELS-1:0] irq
);

  localparam int unsigned PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegReload = 2'd1;
  localparam logic [1:0] RegCount  = 2'd2;
  localparam logic [1:0] RegStatus = 2'd3;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                tick;

  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] per_q, per_d;
  logic [CHANNELS-1:0] ie_q, ie_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] expire;
  logic [CHANNELS-1:0] wsel;
  logic [WIDTH-1:0]    reload_q [CHANNELS];
  logic [WIDTH-1:0]    reload_d [CHANNELS];
  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    count_d  [CHANNELS];
  logic [WIDTH-1:0]    rd_d, rd_q;

  logic [ADDR_W-1:0]   wr_ch, rd_ch;
  logic [1:0]          wr_reg, rd_reg;

  assign wr_ch  = wr_addr >> 2;
  assign rd_ch  = rd_addr >> 2;
  assign wr_reg = wr_addr[1:0];
  assign rd_reg = rd_addr[1:0];

  // Free-running prescaler, independent of register traffic.
  always_comb begin
    tick  = (pre_q == PRE_W'(PRESCALE));
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  // Out-of-range channel indices never match, so those writes fall through.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wsel[i] = wr_en && (wr_ch == ADDR_W'(i));
    end
  end

  always_comb begin
    en_d   = en_q;
    per_d  = per_q;
    ie_d   = ie_q;
    pend_d = pend_q;
    expire = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      reload_d[i] = reload_q[i];
      count_d[i]  = count_q[i];

      // A CTRL write on the tick edge wins; the tick is dropped for this channel.
      if (wsel[i] && wr_reg == RegCtrl) begin
        en_d[i]  = wr_data[0];
        per_d[i] = wr_data[1];
        ie_d[i]  = wr_data[2];
        if (wr_data[0] && !en_q[i]) begin
          count_d[i] = reload_q[i];
        end
      end else if (tick && en_q[i]) begin
        if (count_q[i] != '0) begin
          count_d[i] = count_q[i] - WIDTH'(1);
        end else begin
          expire[i] = 1'b1;
          if (per_q[i]) begin
            count_d[i] = reload_q[i];
          end else begin
            en_d[i] = 1'b0;
          end
        end
      end

      if (wsel[i] && wr_reg == RegReload) begin
        reload_d[i] = wr_data;
      end

      if (wsel[i] && wr_reg == RegStatus && wr_data[0]) begin
        pend_d[i] = 1'b0;
      end
      // Expiry overrides a same-edge clear.
      if (expire[i]) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_ch == ADDR_W'(i)) begin
        case (rd_reg)
          RegCtrl:   rd_d = WIDTH'({ie_q[i], per_q[i], en_q[i]});
          RegReload: rd_d = reload_q[i];
          RegCount:  rd_d = count_q[i];
          RegStatus: rd_d = WIDTH'(pend_q[i]);
          default:   rd_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      en_q   <= '0;
      per_q  <= '0;
      ie_q   <= '0;
      pend_q <= '0;
      rd_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        reload_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      pre_q  <= pre_d;
      en_q   <= en_d;
      per_q  <= per_d;
      ie_q   <= ie_d;
      pend_q <= pend_d;
      rd_q   <= rd_d;
      for (int i = 0; i < CHANNELS; i++) begin
        reload_q[i] <= reload_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  assign rd_data = rd_q;

`ifdef CHINX_TIMER_TOGGLE_EN
  logic [CHANNELS-1:0] tog_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tog_q <= '0;
    end else begin
      tog_q <= tog_q ^ expire;
    end
  end

  assign irq = tog_q;
`else
  assign irq = pend_q & ie_q;
`endif

endmodule

// File: doc/chinx_timer.md
# chinx_timer

Parametrised multi-channel system timer that generates the periodic and one-shot interrupt requests for the core. It replaces the fixed-period tick source with a shared prescaler and CHANNELS independent down-counters, each with a software-visible register file. It sits on the system bus next to the interrupt controller and drives one request line per channel.

## Interface
- WIDTH, 32: data/counter width in bits (min 8).
- CHANNELS, 2: number of independent timer channels (1..8).
- PRESCALE, 10000: prescaler terminal value; one tick every PRESCALE+1 clocks.
- ADDR_W, $clog2(CHANNELS)+2 (1-channel: 2): register address width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  register write strobe, one write per asserted cycle.
- wr_addr  in  ADDR_W  write address {channel, reg[1:0]}.
- wr_data  in  WIDTH  write data.
- rd_addr  in  ADDR_W  read address, same map.
- rd_data  out  WIDTH  registered read data, 1-cycle latency.
- irq  out  CHANNELS  per-channel interrupt request.

## Operation
- Register map per channel (reg[1:0]): 0 CTRL (bit0 EN, bit1 PERIODIC, bit2 IE; other bits read 0); 1 RELOAD (R/W); 2 COUNT (read-only, writes ignored); 3 STATUS (bit0 PENDING; writing 1 to bit0 clears, writing 0 has no effect).
- Addresses for channel index >= CHANNELS: writes ignored, reads return 0.
- Prescaler: counter 0..PRESCALE; emits a 1-cycle tick when it equals PRESCALE, then wraps to 0. Free-running, shared by all channels, unaffected by register writes.
- Channel states: IDLE (EN=0) and RUN (EN=1).
  - IDLE -> RUN: CTRL write with EN=1 loads COUNT <= RELOAD at the same edge.
  - RUN -> RUN on CTRL write with EN=1: COUNT not reloaded; mode/IE bits update.
  - RUN -> IDLE: CTRL write with EN=0; COUNT frozen.
  - On tick in RUN: if COUNT != 0, COUNT <= COUNT-1; if COUNT == 0 (expiry), PENDING <= 1, and PERIODIC ? COUNT <= RELOAD : (EN <= 0, COUNT stays 0).
- RELOAD = 0 in periodic mode expires on every tick.
- RELOAD writes do not affect a running COUNT; they take effect at the next load.
- irq[i] = PENDING[i] & IE[i], driven from registers (no combinational path from the write port).
- Simultaneous STATUS clear and expiry on the same edge: set wins, PENDING stays 1.
- Simultaneous CTRL write and tick on the same edge: the CTRL write wins (load or disable); the tick is not applied to that channel.
- Reset: prescaler 0; all CTRL, RELOAD, COUNT, PENDING 0; rd_data 0; irq 0. Reset mid-count discards all state with no irq glitch.

## Timing
- Write at edge N is visible to a read issued at cycle N+1; rd_data is valid one edge after rd_addr is presented.
- Expiry at tick edge T: PENDING and irq are high from cycle T+1.
- Period in periodic mode: (RELOAD+1)*(PRESCALE+1) clocks between expiries.
- First expiry after enable: RELOAD+1 ticks, with the first tick at a prescaler-dependent offset of 1..PRESCALE+1 clocks.

## Configuration
- CHINX_TIMER_TOGGLE_EN defined: legacy mode. irq[i] toggles on every expiry of channel i, regardless of IE/PENDING, giving a square wave of half-period (RELOAD+1)*(PRESCALE+1). irq resets to 0. PENDING still operates and is readable.
- Not defined: irq is the level PENDING & IE as described above.

## Test plan
- PRESCALE=3, ch0 RELOAD=2, CTRL=0b111 -> PENDING/irq[0] rise every 12 clocks; irq[1] stays 0.
- One-shot: ch1 RELOAD=1, CTRL=0b101 -> irq[1] rises once after 2 ticks; CTRL reads EN=0 and COUNT reads 0 afterwards; STATUS write 1 -> irq[1]=0 next cycle, no further events.
- STATUS clear on the same edge as a periodic expiry (RELOAD=0) -> PENDING stays 1.
- Assert rst while ch0 COUNT=5 and irq=1 -> next cycle irq=0, all registers read 0, no expiry until re-enabled.
- Read/write map: write RELOAD=0xA5 then read -> 0xA5 one cycle later; write to COUNT ignored; out-of-range channel reads 0.
- With CHINX_TIMER_TOGGLE_EN, PRESCALE=9999, RELOAD=0 -> irq[0] toggles every 10000 clocks.
